// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The slave modport is the controller's view; master is the pipeline's view.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_src1_v;
    logic             id_src2_v;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       exe_wb_dest;
    logic             mem_wb_en;
    logic [3:0]       mem_wb_dest;
    logic             exe_branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             stat_clr;

    logic             freeze_pc;
    logic             freeze_if;
    logic             flush_if;
    logic             bubble_id;
    logic             freeze_back;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    modport slave (
        input  id_src1, id_src2, id_src1_v, id_src2_v,
        input  exe_wb_en, exe_mem_r_en, exe_wb_dest,
        input  mem_wb_en, mem_wb_dest,
        input  exe_branch_taken, mem_access, mem_ready, stat_clr,
        output freeze_pc, freeze_if, flush_if, bubble_id, freeze_back,
        output state, stall_count, mem_timeout
    );

    modport master (
        output id_src1, id_src2, id_src1_v, id_src2_v,
        output exe_wb_en, exe_mem_r_en, exe_wb_dest,
        output mem_wb_en, mem_wb_dest,
        output exe_branch_taken, mem_access, mem_ready, stat_clr,
        input  freeze_pc, freeze_if, flush_if, bubble_id, freeze_back,
        input  state, stall_count, mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW / load-use stalls, branch flush and memory-wait freeze,
// with a stall statistics counter and a sticky memory timeout flag.
module pipe_hazard_ctrl #(
    parameter bit          FWD_EN  = 1'b0,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned     WaitW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WaitW-1:0] r_wait_cnt;
    logic [WaitW-1:0] w_wait_cnt_d;
    logic             r_timeout;
    logic             w_timeout_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_d;

    logic w_mem_stall;
    logic w_exe_hit1;
    logic w_exe_hit2;
    logic w_match1;
    logic w_match2;
    logic w_load_use;
    logic w_hazard;
    logic w_valid;

    logic w_freeze_pc;
    logic w_freeze_if;
    logic w_flush_if;
    logic w_bubble_id;
    logic w_freeze_back;

    assign w_mem_stall = bus.mem_access & ~bus.mem_ready;

    assign w_exe_hit1 = bus.exe_wb_en & (bus.id_src1 == bus.exe_wb_dest);
    assign w_exe_hit2 = bus.exe_wb_en & (bus.id_src2 == bus.exe_wb_dest);

    assign w_match1 = bus.id_src1_v &
                      (w_exe_hit1 | (bus.mem_wb_en & (bus.id_src1 == bus.mem_wb_dest)));
    assign w_match2 = bus.id_src2_v &
                      (w_exe_hit2 | (bus.mem_wb_en & (bus.id_src2 == bus.mem_wb_dest)));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_load_use = bus.exe_mem_r_en &
                        ((bus.id_src1_v & w_exe_hit1) | (bus.id_src2_v & w_exe_hit2));

    assign w_hazard = FWD_EN ? w_load_use : (w_match1 | w_match2);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_timeout   <= w_timeout_d;
            r_stall_cnt <= w_stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d    = StRun;
        w_wait_cnt_d = '0;
        case (r_state)
            StRun: begin
                if (w_mem_stall) begin
                    w_state_d    = StMemWait;
                    w_wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (w_mem_stall) begin
                    w_state_d    = StMemWait;
                    w_wait_cnt_d = (r_wait_cnt == WaitMax) ? r_wait_cnt
                                                           : r_wait_cnt + WaitW'(1);
                end
            end
            default: begin
                w_state_d    = StRun;
                w_wait_cnt_d = '0;
            end
        endcase
    end

    assign w_timeout_d = r_timeout | ((w_state_d == StMemWait) && (w_wait_cnt_d == WaitMax));

    // Output logic: identical priority in both legal states, silent otherwise
    assign w_valid = rst & ((r_state == StRun) | (r_state == StMemWait));

    always_comb begin
        w_freeze_pc   = 1'b0;
        w_freeze_if   = 1'b0;
        w_flush_if    = 1'b0;
        w_bubble_id   = 1'b0;
        w_freeze_back = 1'b0;
        if (w_valid) begin
            if (w_mem_stall) begin
                w_freeze_pc   = 1'b1;
                w_freeze_if   = 1'b1;
                w_freeze_back = 1'b1;
            end else if (bus.exe_branch_taken) begin
                w_flush_if  = 1'b1;
                w_bubble_id = 1'b1;
            end else if (w_hazard) begin
                w_freeze_pc = 1'b1;
                w_freeze_if = 1'b1;
                w_bubble_id = 1'b1;
            end
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        if (bus.stat_clr) begin
            w_stall_cnt_d = '0;
        end else if (w_freeze_pc && !(&r_stall_cnt)) begin
            w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.freeze_pc   = w_freeze_pc;
    assign bus.freeze_if   = w_freeze_if;
    assign bus.flush_if    = w_flush_if;
    assign bus.bubble_id   = w_bubble_id;
    assign bus.freeze_back = w_freeze_back;
    assign bus.state       = r_state;
    assign bus.stall_count = r_stall_cnt;
    assign bus.mem_timeout = r_timeout;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FWD_EN, default 0: 1 = forwarding present, so only load-use hazards stall; 0 = every EXE/MEM RAW hazard stalls.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: maximum MEM_WAIT cycles before mem_timeout.
REQ-003 The block SHALL have parameter CNT_W, default 16: stall_count width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 id_src1, id_src2  in  4 each  ID-stage source register numbers.
REQ-007 id_src1_v, id_src2_v  in  1 each  the corresponding source is actually read.
REQ-008 exe_wb_en, exe_mem_r_en  in  1 each; exe_wb_dest  in  4  EXE-stage writeback info.
REQ-009 mem_wb_en  in  1; mem_wb_dest  in  4  MEM-stage writeback info.
REQ-010 exe_branch_taken  in  1  taken branch resolved in EXE.
REQ-011 mem_access  in  1  MEM stage holds a load/store; mem_ready  in  1  memory completes the access this cycle.
REQ-012 stat_clr  in  1  synchronous clear of stall_count.
REQ-013 freeze_pc, freeze_if  out  1 each  hold PC / IF-ID register.
REQ-014 flush_if  out  1  load NOP into IF-ID register.
REQ-015 bubble_id  out  1  load zero controls into ID-EX register.
REQ-016 freeze_back  out  1  hold ID-EX, EX-MEM, MEM-WB registers.
REQ-017 state  out  2  current FSM state; stall_count  out  CNT_W; mem_timeout  out  1, sticky.

Function
REQ-018 The FSM SHALL have states RUN=2'b00 and MEM_WAIT=2'b01; 2'b10 and 2'b11 are illegal and SHALL return to RUN next cycle with all control outputs 0.
REQ-019 mem_stall = mem_access & ~mem_ready; it is combinational (Mealy), effective the same cycle.
REQ-020 match1 = id_src1_v & (id_src1 == exe_wb_dest | id_src1 == mem_wb_dest), using only the EXE/MEM terms whose wb_en=1; match2 is defined likewise for src2.
REQ-021 When FWD_EN=0, hazard = match1 | match2.
REQ-022 When FWD_EN=1, hazard = exe_mem_r_en & exe_wb_en & ((id_src1_v & id_src1==exe_wb_dest) | (id_src2_v & id_src2==exe_wb_dest)).
REQ-023 Priority SHALL be mem_stall > exe_branch_taken > hazard.
REQ-024 On mem_stall (either state): freeze_pc=freeze_if=freeze_back=1; flush_if=bubble_id=0.
REQ-025 On branch without mem_stall: flush_if=bubble_id=1; freezes=0.
REQ-026 On hazard only: freeze_pc=freeze_if=bubble_id=1; flush_if=freeze_back=0.
REQ-027 With no condition active, all control outputs SHALL be 0.
REQ-028 In RUN, mem_stall SHALL move the FSM to MEM_WAIT and load wait_cnt=1.
REQ-029 In MEM_WAIT, mem_ready=1 or mem_access=0 SHALL return the FSM to RUN.
REQ-030 In MEM_WAIT, the branch/hazard outputs SHALL apply in the exit cycle only if mem_stall=0.
REQ-031 In MEM_WAIT, wait_cnt SHALL increment each stalled cycle and saturate at TIMEOUT.
REQ-032 On the cycle wait_cnt reaches TIMEOUT, mem_timeout SHALL set and stay 1 until reset; the FSM SHALL stay in MEM_WAIT.
REQ-033 stall_count SHALL increment each cycle freeze_pc=1 and saturate at all-ones.
REQ-034 stat_clr SHALL take precedence over the increment: next value is 0.
REQ-035 Register 0 gets no special treatment; it matches like any other register.

Reset
REQ-036 While rst=0 at a clock edge: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
REQ-037 During reset the combinational outputs SHALL be forced to 0.
REQ-038 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no pending branch or hazard memory.

Verification
REQ-039 FWD_EN=0, exe_wb_en=1, exe_wb_dest=5, id_src1=5, id_src1_v=1 -> freeze_pc=freeze_if=bubble_id=1, stall_count +1 per cycle.
REQ-040 FWD_EN=1, same stimulus with exe_mem_r_en=0 -> no stall; with exe_mem_r_en=1 -> one-cycle stall.
REQ-041 mem_access=1, mem_ready low for 3 cycles -> state=01 for 3 cycles, freeze_back=1, stall_count=3, then RUN.
REQ-042 exe_branch_taken=1 with mem_stall=1 -> freezes only; on the mem_ready cycle -> flush_if=bubble_id=1.
REQ-043 TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 on the 4th wait cycle; it stays 1 after mem_ready; only rst=0 clears it.
REQ-044 stall_count=16'hFFFF with a further stall -> holds 16'hFFFF; stat_clr=1 with a stall -> 0.
